fsm_step_guard: RTL and testbench
=================================

// Module: fsm_step_guard
// PURPOSE
//  Sequencing controller around a 4-state one-hot transition mux. Holds the state register and
//  advances it only on qualified step requests. Detects illegal (non-one-hot) codes and
//  stuck-state timeouts, and recovers to IDLE with a sticky alarm. Sits between the security
//  FSM datapath and the alarm/interrupt aggregator.
// PARAMETERS
//  TIMEOUT   32  Max consecutive accepted-but-unchanged steps before watchdog trip (>=2)
//  CNT_W     6   Watchdog counter width; must hold TIMEOUT
// PORTS
//  clk         in   1  Sole clock; all logic on posedge
//  rst         in   1  Synchronous, active-high reset
//  step_valid  in   1  Request to evaluate one transition
//  step_ready  out  1  Controller can accept a step this cycle
//  cond_a      in   1  Qualifier, sampled only when step_valid & step_ready
//  cond_b      in   1  Qualifier, sampled only when step_valid & step_ready
//  load_en     in   1  Debug/fault-inject: overwrite state register
//  load_val    in   4  Value written when load_en (may be illegal)
//  alarm_clr   in   1  Clears sticky alarm flags
//  state       out  4  Current registered state
//  step_done   out  1  1-cycle pulse: accepted step committed
//  alarm_ill   out  1  Sticky: illegal state code detected
//  alarm_wdt   out  1  Sticky: watchdog timeout
// BEHAVIOUR
//  States (one-hot): IDLE=4'b0001, ARM=4'b0010, FIRE=4'b0100, DONE=4'b1000.
//  Next-state on accepted step: IDLE->ARM if cond_a else IDLE. ARM->FIRE if cond_b else IDLE.
//   FIRE->DONE. DONE->IDLE. Any other code -> IDLE.
//  Reset: state=IDLE, step_ready=0 for exactly one cycle after rst deasserts, then 1.
//   step_done=0, alarm_ill=0, alarm_wdt=0, wdt counter=0.
//  Handshake: accept = step_valid & step_ready. The new state is visible the cycle after accept.
//   step_done pulses in that same cycle. Latency is 1. Back-to-back accepts are allowed, one per cycle.
//  Illegal detect: each cycle, if state is not one-hot (popcount != 1), the next cycle gives
//   state=IDLE and alarm_ill=1. step_ready=0 during the illegal cycle. A step_valid in that cycle
//   is not accepted and gets no step_done.
//  Watchdog: counter +1 on each accept whose next state equals the current state (IDLE self-loop).
//   Counter clears on any accept that changes state, and on recovery. When counter reaches
//   TIMEOUT: next cycle counter=0, alarm_wdt=1, state=IDLE. Counter saturates and never wraps.
//  Priority, highest first: rst > load_en > illegal recovery > accepted step. load_en with
//   step_valid: load wins, step not accepted, no step_done. A loaded illegal value is flagged
//   on the following cycle.
//  alarm_clr: clears both alarms next cycle. If a new alarm event happens in the same cycle,
//   the alarm stays set (set wins over clear).
//  Reset mid-step: a pending accept is discarded and no step_done is issued.
// STRUCTURE
//  Package fsm_sec_pkg: localparams ST_IDLE/ST_ARM/ST_FIRE/ST_DONE, STATE_W=4, function is_onehot().
//  Sub-module fsm_next_state: purely combinational next-state mux (state, cond_a, cond_b ->
//   nxt, illegal). The top level holds the registers, handshake, watchdog and alarms.
// TESTING
//  1 Reset, then steps (a=1),(b=1),(-),(-) -> state 0010,0100,1000,0001; 4 step_done pulses.
//  2 At ARM, step with b=0 -> state 0001, counter stays 0, no alarm.
//  3 load_val=4'b0110 -> next cycle state=0001, alarm_ill=1; alarm_clr -> alarm_ill=0.
//  4 TIMEOUT=4: 4 steps at IDLE with a=0 -> alarm_wdt=1, counter=0, state=0001.
//  5 load_en and step_valid in the same cycle -> loaded value wins, no step_done.
//  6 alarm_clr in the same cycle as an illegal detect -> alarm_ill remains 1.

Source files
------------

// File: rtl/fsm_sec_pkg.sv
// Shared encodings and helpers for the guarded step controller.
// The state register stays a raw 4-bit vector so it can hold illegal codes.
package fsm_sec_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE = 4'b0001;
    localparam logic [STATE_W-1:0] ST_ARM  = 4'b0010;
    localparam logic [STATE_W-1:0] ST_FIRE = 4'b0100;
    localparam logic [STATE_W-1:0] ST_DONE = 4'b1000;

    // Which source updates the state register this cycle, highest priority first.
    typedef enum logic [1:0] {
        UPD_LOAD    = 2'd0,
        UPD_RECOVER = 2'd1,
        UPD_STEP    = 2'd2,
        UPD_HOLD    = 2'd3
    } updSel_e;

    function automatic logic is_onehot(input logic [STATE_W-1:0] code);
        return ($countones(code) == 1);
    endfunction

endpackage

// File: rtl/fsm_next_state.sv
// Pure combinational transition mux for the one-hot sequencing FSM.
// Also flags any state code that is not exactly one-hot.
module fsm_next_state
    import fsm_sec_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic               cond_a_i,
    input  logic               cond_b_i,
    output logic [STATE_W-1:0] nxt_o,
    output logic               illegal_o
);

    always_comb begin
        nxt_o = ST_IDLE;
        case (state_i)
            ST_IDLE: nxt_o = cond_a_i ? ST_ARM : ST_IDLE;
            ST_ARM:  nxt_o = cond_b_i ? ST_FIRE : ST_IDLE;
            ST_FIRE: nxt_o = ST_DONE;
            ST_DONE: nxt_o = ST_IDLE;
            default: nxt_o = ST_IDLE;
        endcase
    end

    always_comb begin
        illegal_o = !is_onehot(state_i);
    end

endmodule

// File: rtl/fsm_step_guard.sv
// Step-request controller around the one-hot transition mux: handshake, watchdog,
// illegal-code recovery and sticky alarms.
module fsm_step_guard
    import fsm_sec_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_valid,
    output logic               step_ready,
    input  logic               cond_a,
    input  logic               cond_b,
    input  logic               load_en,
    input  logic [STATE_W-1:0] load_val,
    input  logic               alarm_clr,
    output logic [STATE_W-1:0] state,
    output logic               step_done,
    output logic               alarm_ill,
    output logic               alarm_wdt
);

    localparam logic [CNT_W-1:0] WDT_LIMIT = CNT_W'(TIMEOUT);

    logic [STATE_W-1:0] state_q,    state_d;
    logic               ready_q,    ready_d;
    logic               stepDone_q, stepDone_d;
    logic               alarmIll_q, alarmIll_d;
    logic               alarmWdt_q, alarmWdt_d;
    logic [CNT_W-1:0]   wdtCnt_q,   wdtCnt_d;

    logic [STATE_W-1:0] nxtState;
    logic               illegal;
    logic               wdtTrip;
    logic               recover;
    logic               readyInt;
    logic               accept;
    logic               illSet;
    logic               wdtSet;
    updSel_e            updSel;

    fsm_next_state u_next (
        .state_i   (state_q),
        .cond_a_i  (cond_a),
        .cond_b_i  (cond_b),
        .nxt_o     (nxtState),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            stepDone_q <= 1'b0;
            alarmIll_q <= 1'b0;
            alarmWdt_q <= 1'b0;
            wdtCnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            stepDone_q <= stepDone_d;
            alarmIll_q <= alarmIll_d;
            alarmWdt_q <= alarmWdt_d;
            wdtCnt_q   <= wdtCnt_d;
        end
    end

    // A recovery cycle or a debug load blocks the handshake so no step can slip through.
    always_comb begin
        wdtTrip  = (wdtCnt_q >= WDT_LIMIT);
        recover  = illegal || wdtTrip;
        readyInt = ready_q && !recover && !load_en;
        accept   = step_valid && readyInt;

        if (load_en) begin
            updSel = UPD_LOAD;
        end else if (recover) begin
            updSel = UPD_RECOVER;
        end else if (accept) begin
            updSel = UPD_STEP;
        end else begin
            updSel = UPD_HOLD;
        end
    end

    always_comb begin
        state_d    = state_q;
        wdtCnt_d   = wdtCnt_q;
        stepDone_d = 1'b0;
        ready_d    = 1'b1;
        illSet     = 1'b0;
        wdtSet     = 1'b0;

        case (updSel)
            UPD_LOAD: begin
                state_d = load_val;
            end
            UPD_RECOVER: begin
                state_d  = ST_IDLE;
                wdtCnt_d = '0;
                illSet   = illegal;
                wdtSet   = wdtTrip;
            end
            UPD_STEP: begin
                state_d    = nxtState;
                stepDone_d = 1'b1;
                if (nxtState != state_q) begin
                    wdtCnt_d = '0;
                end else if (wdtCnt_q < WDT_LIMIT) begin
                    wdtCnt_d = wdtCnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A fresh alarm event beats a clear requested in the same cycle.
        alarmIll_d = illSet || (alarmIll_q && !alarm_clr);
        alarmWdt_d = wdtSet || (alarmWdt_q && !alarm_clr);
    end

    always_comb begin
        state      = state_q;
        step_ready = readyInt;
        step_done  = stepDone_q;
        alarm_ill  = alarmIll_q;
        alarm_wdt  = alarmWdt_q;
    end

endmodule

// File: tb/tb_fsm_step_guard.sv
// Directed self-checking bench for fsm_step_guard with a short watchdog (TIMEOUT=4).
module tb_fsm_step_guard;

    logic       clk = 1'b0;
    logic       rst;
    logic       step_valid;
    logic       step_ready;
    logic       cond_a;
    logic       cond_b;
    logic       load_en;
    logic [3:0] load_val;
    logic       alarm_clr;
    logic [3:0] state;
    logic       step_done;
    logic       alarm_ill;
    logic       alarm_wdt;

    int compareCount  = 0;
    int mismatchCount = 0;

    fsm_step_guard #(
        .TIMEOUT (4),
        .CNT_W   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .cond_a     (cond_a),
        .cond_b     (cond_b),
        .load_en    (load_en),
        .load_val   (load_val),
        .alarm_clr  (alarm_clr),
        .state      (state),
        .step_done  (step_done),
        .alarm_ill  (alarm_ill),
        .alarm_wdt  (alarm_wdt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Sets every input, then lets combinational outputs settle before any check.
    task automatic applyStimulus(input logic r, input logic v, input logic a, input logic b,
                                 input logic ld, input logic [3:0] lv, input logic clr);
        rst        = r;
        step_valid = v;
        cond_a     = a;
        cond_b     = b;
        load_en    = ld;
        load_val   = lv;
        alarm_clr  = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic stepIdle(input logic a);
        applyStimulus(1'b0, 1'b1, a, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        tick();
        checkOutput("rst_state", 8'(state), 8'h01);
        checkOutput("rst_done", 8'(step_done), 8'h0);
        checkOutput("rst_alarms", 8'({alarm_ill, alarm_wdt}), 8'h0);

        idle();
        checkOutput("rst_ready_gap", 8'(step_ready), 8'h0);
        tick();
        checkOutput("rst_ready_on", 8'(step_ready), 8'h1);

        // Full walk IDLE->ARM->FIRE->DONE->IDLE, back-to-back accepts.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("walk_arm", 8'({step_done, state}), 8'h12);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("walk_fire", 8'({step_done, state}), 8'h14);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("walk_done", 8'({step_done, state}), 8'h18);
        tick();
        checkOutput("walk_idle", 8'({step_done, state}), 8'h11);
        idle();
        tick();
        checkOutput("walk_quiet", 8'({step_done, state}), 8'h01);

        // Self-loops then state changes: counter must clear on ARM and on ARM->IDLE.
        stepIdle(1'b0);
        stepIdle(1'b0);
        stepIdle(1'b1);
        checkOutput("cnt_arm", 8'(state), 8'h02);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("arm_b0_idle", 8'({step_done, state}), 8'h11);
        stepIdle(1'b0);
        stepIdle(1'b0);
        stepIdle(1'b0);
        idle();
        checkOutput("wdt_three_ready", 8'(step_ready), 8'h1);
        tick();
        checkOutput("wdt_three_noalarm", 8'(alarm_wdt), 8'h0);

        // Fourth self-loop reaches TIMEOUT: trip cycle blocks steps, then alarm.
        stepIdle(1'b0);
        checkOutput("wdt_fourth_done", 8'({step_done, alarm_wdt}), 8'h2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        checkOutput("wdt_trip_ready", 8'(step_ready), 8'h0);
        tick();
        checkOutput("wdt_alarm", 8'({alarm_wdt, state}), 8'h11);
        checkOutput("wdt_trip_nodone", 8'(step_done), 8'h0);

        // Counter was cleared by the trip: after clearing the alarm, 3 loops must not trip.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("wdt_clr", 8'(alarm_wdt), 8'h0);
        stepIdle(1'b0);
        stepIdle(1'b0);
        stepIdle(1'b0);
        idle();
        tick();
        checkOutput("wdt_restart", 8'({step_ready, alarm_wdt}), 8'h2);

        // Illegal load: flagged next cycle, step refused, recovered to IDLE.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
        tick();
        checkOutput("ill_loaded", 8'({alarm_ill, state}), 8'h06);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        checkOutput("ill_ready", 8'(step_ready), 8'h0);
        tick();
        checkOutput("ill_recover", 8'({step_done, alarm_ill, state}), 8'h11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("ill_clr", 8'(alarm_ill), 8'h0);

        // Load and step together: load wins, no step_done.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0);
        checkOutput("load_ready", 8'(step_ready), 8'h0);
        tick();
        checkOutput("load_wins", 8'({step_done, state}), 8'h04);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("load_then_step", 8'({step_done, state}), 8'h18);

        // Raise the watchdog alarm again so the next clear has something to clear.
        tick();
        stepIdle(1'b0);
        stepIdle(1'b0);
        stepIdle(1'b0);
        stepIdle(1'b0);
        idle();
        tick();
        checkOutput("wdt_again", 8'(alarm_wdt), 8'h1);

        // Clear in the same cycle as an illegal detect: alarm_ill set wins, alarm_wdt clears.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("clr_vs_ill", 8'({alarm_ill, alarm_wdt, state}), 8'h21);

        // Reset during an accepted step: no step_done, back to IDLE, ready gap.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("rst_mid_step", 8'({step_done, alarm_ill, state}), 8'h01);
        idle();
        checkOutput("rst_mid_ready", 8'(step_ready), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
